reg_file_sb: RTL and testbench

- Register file plus busy-bit scoreboard for the MiniRISC core.
- Consumes the 5-bit write-register index from the write-destination select stage (rt / rd / link register 31), together with the writeback data.
- Provides two combinational read ports with write-through bypass.
- Tracks in-flight destinations so decode can stall on RAW and WAW hazards.

---
 rtl/reg_file_sb.sv | 107 ++++++++++
 tb/tb_reg_file_sb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb -- MiniRISC register file with busy-bit scoreboard.
//
// Holds 2**ADDR_W registers (r0 hard-wired to zero), two combinational read
// ports with write-through bypass from the writeback port, and one busy bit
// per register tracking in-flight producers so decode can stall on RAW/WAW.
//
// Optional feature macro: REGFILE_SP_INIT_EN
//   defined   -> r29 (stack pointer) resets to SP_INIT
//   undefined -> every register resets to zero
//
// Ports:
//   clk, rst_n            clock (rising edge) / async active-low reset
//   rs_addr, rt_addr      read indices
//   rs_data, rt_data      read data (bypassed from writeback)
//   wr_en/wr_addr/wr_data writeback port
//   issue_en/issue_addr   destination of the instruction leaving decode
//   rs_busy, rt_busy      read operand has an outstanding producer
//   stall                 decode must hold this cycle
module reg_file_sb #(
    parameter int              DATA_W  = 32,
    parameter int              ADDR_W  = 5,
    parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_03FC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              stall
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int SP_IX = 29;

`ifdef REGFILE_SP_INIT_EN
    localparam logic [DATA_W-1:0] SP_RST = SP_INIT;
`else
    localparam logic [DATA_W-1:0] SP_RST = (SP_INIT & '0);
`endif

    logic [NREG-1:0][DATA_W-1:0] regs_q;
    logic [NREG-1:0]             busy_q;

    // Writeback qualifiers; r0 is never a real destination.
    logic wr_nz, wr_hit_rs, wr_hit_rt, wr_hit_iss;
    logic rs_busy_d, rt_busy_d, waw_d, stall_d;
    logic issue_ok;

    always_comb begin
        wr_nz      = wr_en & (wr_addr != '0);
        wr_hit_rs  = wr_en & (wr_addr == rs_addr);
        wr_hit_rt  = wr_en & (wr_addr == rt_addr);
        wr_hit_iss = wr_en & (wr_addr == issue_addr);

        // A writeback landing this cycle resolves the hazard it would raise.
        rs_busy_d = busy_q[rs_addr] & ~wr_hit_rs & (rs_addr != '0);
        rt_busy_d = busy_q[rt_addr] & ~wr_hit_rt & (rt_addr != '0);
        waw_d     = issue_en & (issue_addr != '0) & busy_q[issue_addr] & ~wr_hit_iss;
        stall_d   = rs_busy_d | rt_busy_d | waw_d;

        issue_ok  = issue_en & ~stall_d & (issue_addr != '0);
    end

    // Outputs forced to zero while reset is held, even if the writeback
    // port is toggling, so nothing downstream sees stale bypass data.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rst_n) begin
            if (rs_addr != '0) rs_data = (wr_nz && wr_hit_rs) ? wr_data : regs_q[rs_addr];
            if (rt_addr != '0) rt_data = (wr_nz && wr_hit_rt) ? wr_data : regs_q[rt_addr];
        end
    end

    assign rs_busy = rst_n & rs_busy_d;
    assign rt_busy = rst_n & rt_busy_d;
    assign stall   = rst_n & stall_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == SP_IX) ? SP_RST : '0;
                busy_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wr_en && wr_addr == ADDR_W'(i))
                    regs_q[i] <= wr_data;
                // Set wins over clear: a new producer issued on the same
                // edge as the old one retires owns the register.
                if (issue_ok && issue_addr == ADDR_W'(i))
                    busy_q[i] <= 1'b1;
                else if (wr_en && wr_addr == ADDR_W'(i))
                    busy_q[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] rs_addr, rt_addr, wr_addr, issue_addr;
    logic [DATA_W-1:0] rs_data, rt_data, wr_data;
    logic              wr_en, issue_en;
    logic              rs_busy, rt_busy, stall;

    int checks = 0;
    int failures = 0;

    reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SP_INIT(32'h0000_03FC)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .rs_busy(rs_busy), .rt_busy(rt_busy), .stall(stall)
    );

    always #5 clk = ~clk;

    // advance to 1 time unit past the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_data = 0;
        issue_en = 0; issue_addr = 0;
        rs_addr = 0; rt_addr = 0;
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] exp;
        rst_n = 0;
        idle();
        step();
        // outputs during reset with a writeback driven
        wr_en = 1; wr_addr = 5; wr_data = 32'h1111_2222; rs_addr = 5;
        #1; checks++;
        if (rs_data !== 32'h0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold rs_data=%h stall=%b required 0/0", rs_data, stall);
        end
        idle();
        step();
        rst_n = 1;
        step();
        for (int i = 0; i < 32; i++) begin
            rs_addr = ADDR_W'(i);
            rt_addr = ADDR_W'(31 - i);
            #1;
            exp = 32'h0;
`ifdef REGFILE_SP_INIT_EN
            if (i == 29) exp = 32'h0000_03FC;
`endif
            checks++;
            if (rs_data !== exp) begin
                failures++;
                $display("FAIL reset_rs[%0d] got %h required %h", i, rs_data, exp);
            end
            exp = 32'h0;
`ifdef REGFILE_SP_INIT_EN
            if (31 - i == 29) exp = 32'h0000_03FC;
`endif
            checks++;
            if (rt_data !== exp) begin
                failures++;
                $display("FAIL reset_rt[%0d] got %h required %h", 31 - i, rt_data, exp);
            end
            checks++;
            if ({rs_busy, rt_busy, stall} !== 3'b000) begin
                failures++;
                $display("FAIL reset_busy[%0d] got %b required 000", i, {rs_busy, rt_busy, stall});
            end
        end
        idle();
    endtask

    task automatic test_r0();
        wr_en = 1; wr_addr = 0; wr_data = 32'hDEAD_BEEF; rs_addr = 0;
        #1; checks++;
        if (rs_data !== 32'h0) begin
            failures++;
            $display("FAIL r0_bypass got %h required 0", rs_data);
        end
        step();
        wr_en = 0;
        #1; checks++;
        if (rs_data !== 32'h0) begin
            failures++;
            $display("FAIL r0_read got %h required 0", rs_data);
        end
        issue_en = 1; issue_addr = 0;
        step();
        // a second issue to r0 must not see a WAW hazard
        #1; checks++;
        if (stall !== 1'b0 || rs_busy !== 1'b0) begin
            failures++;
            $display("FAIL r0_issue stall=%b rs_busy=%b required 0/0", stall, rs_busy);
        end
        idle();
    endtask

    task automatic test_write_bypass();
        rs_addr = 5;
        wr_en = 1; wr_addr = 5; wr_data = 32'h1234_5678;
        #1; checks++;
        if (rs_data !== 32'h1234_5678) begin
            failures++;
            $display("FAIL bypass_r5 got %h required 12345678", rs_data);
        end
        step();
        wr_en = 0; wr_data = 0;
        for (int k = 0; k < 2; k++) begin
            #1; checks++;
            if (rs_data !== 32'h1234_5678) begin
                failures++;
                $display("FAIL read_r5[%0d] got %h required 12345678", k, rs_data);
            end
            step();
        end
        idle();
    endtask

    task automatic test_raw();
        issue_en = 1; issue_addr = 7;
        #1; checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL raw_issue stall=%b required 0", stall);
        end
        step();
        issue_en = 0; rt_addr = 7;
        #1; checks++;
        if (rt_busy !== 1'b1 || stall !== 1'b1) begin
            failures++;
            $display("FAIL raw_busy rt_busy=%b stall=%b required 1/1", rt_busy, stall);
        end
        wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5_0001;
        #1; checks++;
        if (rt_busy !== 1'b0 || stall !== 1'b0 || rt_data !== 32'hA5A5_0001) begin
            failures++;
            $display("FAIL raw_resolve rt_busy=%b stall=%b rt_data=%h required 0/0/a5a50001",
                     rt_busy, stall, rt_data);
        end
        step();
        wr_en = 0;
        #1; checks++;
        if (rt_busy !== 1'b0 || rt_data !== 32'hA5A5_0001) begin
            failures++;
            $display("FAIL raw_after rt_busy=%b rt_data=%h required 0/a5a50001", rt_busy, rt_data);
        end
        idle();
    endtask

    task automatic test_same_edge();
        issue_en = 1; issue_addr = 9;
        wr_en = 1; wr_addr = 9; wr_data = 32'h0000_0999;
        step();
        issue_en = 0; wr_en = 0; rs_addr = 9;
        #1; checks++;
        if (rs_busy !== 1'b1 || stall !== 1'b1 || rs_data !== 32'h0000_0999) begin
            failures++;
            $display("FAIL same_edge rs_busy=%b stall=%b rs_data=%h required 1/1/00000999",
                     rs_busy, stall, rs_data);
        end
        // retire the new producer, busy must then be clear
        wr_en = 1; wr_addr = 9; wr_data = 32'h0000_0111;
        step();
        wr_en = 0;
        #1; checks++;
        if (rs_busy !== 1'b0 || rs_data !== 32'h0000_0111) begin
            failures++;
            $display("FAIL same_edge_retire rs_busy=%b rs_data=%h required 0/00000111", rs_busy, rs_data);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            wr_en = 1; wr_addr = ADDR_W'(10 + k); wr_data = 32'hC000_0000 + k;
            step();
        end
        wr_en = 0;
        for (int k = 0; k < 4; k += 2) begin
            rs_addr = ADDR_W'(10 + k);
            rt_addr = ADDR_W'(11 + k);
            #1; checks++;
            if (rs_data !== 32'hC000_0000 + k || rt_data !== 32'hC000_0001 + k) begin
                failures++;
                $display("FAIL b2b[%0d] rs=%h rt=%h required %h/%h", k, rs_data, rt_data,
                         32'hC000_0000 + k, 32'hC000_0001 + k);
            end
        end
        idle();
    endtask

    task automatic test_waw_reset();
        issue_en = 1; issue_addr = 3;
        step();
        // busy[3] set; reissue with no writeback -> WAW stall
        #1; checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL waw_stall stall=%b required 1", stall);
        end
        step();
        issue_en = 0; rs_addr = 3;
        #1; checks++;
        if (rs_busy !== 1'b1) begin
            failures++;
            $display("FAIL waw_busy_kept rs_busy=%b required 1", rs_busy);
        end
        // stalled issue of r11 must not set busy[11]
        issue_en = 1; issue_addr = 11;
        step();
        issue_en = 0; rs_addr = 11;
        #1; checks++;
        if (rs_busy !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL stalled_issue rs_busy=%b stall=%b required 0/0", rs_busy, stall);
        end
        rs_addr = 3;
        #2;
        rst_n = 0;
        #1; checks++;
        if (rs_busy !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset rs_busy=%b stall=%b required 0/0", rs_busy, stall);
        end
        step();
        rst_n = 1;
        rs_addr = 5; rt_addr = 3;
        #1; checks++;
        if (rs_data !== 32'h0 || rt_busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset rs_data=%h rt_busy=%b required 0/0", rs_data, rt_busy);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_r0();
        test_write_bypass();
        test_raw();
        test_same_edge();
        test_back_to_back();
        test_waw_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
